shader_color_fifo: RTL
======================

Name: shader_color_fifo

Overview:
- Downstream stage of the shader pipeline. Captures each RGB result qualified by color_valid into a single-clock FIFO.
- Serves the captured pixels in order to the HDMI display timing/encoder path on per-pixel read requests.
- Decouples the shader's variable multi-cycle latency from the fixed display cadence.
- Provides back-pressure, priming, underrun fallback colour and per-frame flush.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- ADDR_WIDTH, 4, log2(DEPTH).
- PRIME_LEVEL, 8, occupancy required before the first pixel of a frame is served.
- AFULL_LEVEL, 12, occupancy at or above which afull is asserted.
- FALLBACK_RGB, 24'h101030, colour output on underrun.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame; flushes the FIFO and restarts priming.
- red_in  in  8  shader red result.
- green_in  in  8  shader green result.
- blue_in  in  8  shader blue result.
- color_valid  in  1  write strobe, one cycle per pixel.
- afull  out  1  occupancy >= AFULL_LEVEL; upstream stops issuing pixel_valid while high.
- pix_req  in  1  display consumes one pixel this cycle.
- red_out  out  8  registered output pixel, red.
- green_out  out  8  registered output pixel, green.
- blue_out  out  8  registered output pixel, blue.
- pix_out_valid  out  1  red/green/blue_out correspond to a pix_req issued 1 cycle earlier.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- underrun  out  1  sticky; set on any underrun; cleared by frame_start or rst.
- overflow_cnt  out  8  count of writes dropped because the FIFO was full; saturates at 255; cleared by rst only.

Behaviour:
- Reset (asynchronous): state=PRIME, read/write pointers 0, level 0, all RGB outputs 0, pix_out_valid 0, afull 0, underrun 0, overflow_cnt 0.
- Write: color_valid with level<DEPTH stores {red,green,blue} at wptr; wptr advances modulo DEPTH.
- Write when full with no same-cycle pop: data dropped, overflow_cnt increments (saturating).
- Read latency: pix_req in cycle N produces outputs and pix_out_valid=1 in cycle N+1.
- pix_req=0 in cycle N gives pix_out_valid=0 in N+1; RGB outputs hold their last value.
- State machine:
  - PRIME: pix_req returns FALLBACK_RGB, no pop, underrun not set. Moves to RUN when level >= PRIME_LEVEL.
  - RUN: pix_req with level>0 pops the head entry. pix_req with level==0 outputs FALLBACK_RGB, sets underrun, moves to UNDERRUN.
  - UNDERRUN: every pix_req returns FALLBACK_RGB with no pop (holds output alignment); writes are still accepted. Leaves only on frame_start.
  - frame_start, from any state: next state PRIME; pointers and level cleared; underrun cleared.
- Simultaneous events:
  - Push and pop in the same cycle in RUN: legal at any level including full (full: the pop frees the slot, write accepted, level unchanged). At level 0, a pop is an underrun and the write is stored.
  - frame_start has priority over the same-cycle push and pop: both are discarded and are not counted as overflow.
- level is exact every cycle: +1 on push only, -1 on pop only, 0 on flush.
- afull is combinational from level; it may over-assert by one cycle, but never under-asserts.
- Pointers wrap naturally at DEPTH; full/empty are decided from level, never from pointer equality alone.

Decomposition:
- Shared package holds:
  - the RGB pixel struct/width constant (24) and the FALLBACK_RGB default;
  - the state encoding PRIME/RUN/UNDERRUN (2-bit).
- One sub-module, sync_fifo_ram: DEPTH x 24 dual-port storage, synchronous write, registered read. It is reusable by later line buffers.
- Control, level tracking and the state machine live in shader_color_fifo.

Test Plan:
- Reset, then 8 writes of 0x010203..0x080808 with no pix_req. Then pulse pix_req 8 times: state reaches RUN on the 8th write; outputs are exactly the 8 values in order, each one cycle after its pix_req; level returns to 0.
- pix_req during PRIME with level=3: output 0x101030, level stays 3, underrun=0.
- Fill to 16 in RUN, then 3 more writes without reads: overflow_cnt=3, level=16, afull=1 (afull first seen at level 12).
- At level 16, push and pop in the same cycle: output is the oldest entry, new data stored, level stays 16, overflow_cnt unchanged.
- In RUN at level 0, pix_req: output 0x101030, underrun=1, state UNDERRUN. Further writes raise level but pix_req still returns fallback. frame_start then gives level 0, underrun 0, state PRIME.
- frame_start coincident with color_valid and pix_req at level 5: level=0 next cycle, no overflow count, pix_out_valid=1 with fallback colour. Assert rst mid-stream: all outputs go to their reset values with no clock edge.

Source files
------------

// File: rtl/shader_color_fifo_pkg.sv
// Shared types and defaults for the shader colour FIFO: pixel layout and control states.
package shader_color_fifo_pkg;

    localparam int unsigned RGB_W = 24;
    localparam logic [RGB_W-1:0] FALLBACK_RGB_DEFAULT = 24'h101030;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        StPrime    = 2'd0,
        StRun      = 2'd1,
        StUnderrun = 2'd2
    } state_e;

endpackage

// File: rtl/shader_color_fifo_if.sv
// Shader-to-display pixel interface: write side, read side and status.
interface shader_color_fifo_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic                  frame_start;
    logic [7:0]            red_in;
    logic [7:0]            green_in;
    logic [7:0]            blue_in;
    logic                  color_valid;
    logic                  afull;
    logic                  pix_req;
    logic [7:0]            red_out;
    logic [7:0]            green_out;
    logic [7:0]            blue_out;
    logic                  pix_out_valid;
    logic [ADDR_WIDTH:0]   level;
    logic                  underrun;
    logic [7:0]            overflow_cnt;

    modport slave (
        input  frame_start, red_in, green_in, blue_in, color_valid, pix_req,
        output afull, red_out, green_out, blue_out, pix_out_valid, level, underrun,
               overflow_cnt
    );

    modport master (
        output frame_start, red_in, green_in, blue_in, color_valid, pix_req,
        input  afull, red_out, green_out, blue_out, pix_out_valid, level, underrun,
               overflow_cnt
    );
endinterface

// File: rtl/shader_color_fifo_sync_fifo_ram.sv
// DEPTH x WIDTH dual-port storage: synchronous write, registered read (read-before-write).
module sync_fifo_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WIDTH      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read data holds between reads so the consumer sees a stable pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/shader_color_fifo.sv
// Pixel FIFO between shader and display: priming, underrun fallback, per-frame flush.
module shader_color_fifo
    import shader_color_fifo_pkg::*;
#(
    parameter int unsigned      DEPTH        = 16,
    parameter int unsigned      ADDR_WIDTH   = 4,
    parameter int unsigned      PRIME_LEVEL  = 8,
    parameter int unsigned      AFULL_LEVEL  = 12,
    parameter logic [RGB_W-1:0] FALLBACK_RGB = FALLBACK_RGB_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    shader_color_fifo_if.slave  bus_if
);

    localparam logic [ADDR_WIDTH:0] LVL_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_PRIME = (ADDR_WIDTH+1)'(PRIME_LEVEL);
    localparam logic [ADDR_WIDTH:0] LVL_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    state_e                r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]   r_level, w_level_d;
    logic                  r_underrun, r_use_fb, r_pix_out_valid;
    logic [7:0]            r_ovf_cnt;

    logic w_empty, w_full, w_pop, w_push, w_drop, w_underrun_evt;
    rgb_t w_wr_px, w_rd_px, w_out_px;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // frame_start discards any same-cycle push or pop.
    assign w_pop          = bus_if.pix_req && (r_state == StRun) && !w_empty && !bus_if.frame_start;
    assign w_push         = bus_if.color_valid && !bus_if.frame_start && (!w_full || w_pop);
    assign w_drop         = bus_if.color_valid && !bus_if.frame_start && w_full && !w_pop;
    assign w_underrun_evt = bus_if.pix_req && (r_state == StRun) && w_empty && !bus_if.frame_start;

    assign w_wr_px = '{r: bus_if.red_in, g: bus_if.green_in, b: bus_if.blue_in};

    sync_fifo_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (RGB_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wr_px),
        .i_re    (w_pop),
        .i_raddr (r_rptr),
        .o_rdata (w_rd_px)
    );

    always_comb begin
        w_state_d = r_state;
        if (bus_if.frame_start) begin
            w_state_d = StPrime;
        end else begin
            unique case (r_state)
                StPrime:    if (r_level >= LVL_PRIME) w_state_d = StRun;
                StRun:      if (w_underrun_evt) w_state_d = StUnderrun;
                StUnderrun: w_state_d = StUnderrun;
                default:    w_state_d = StPrime;
            endcase
        end
    end

    always_comb begin
        w_level_d = r_level;
        if (bus_if.frame_start)    w_level_d = '0;
        else if (w_push && !w_pop) w_level_d = r_level + 1'b1;
        else if (w_pop && !w_push) w_level_d = r_level - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= StPrime;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_level         <= '0;
            r_underrun      <= 1'b0;
            r_use_fb        <= 1'b0;
            r_pix_out_valid <= 1'b0;
            r_ovf_cnt       <= '0;
        end else begin
            r_state         <= w_state_d;
            r_level         <= w_level_d;
            r_pix_out_valid <= bus_if.pix_req;
            // Output source only changes on a request, so idle cycles hold the last colour.
            if (bus_if.pix_req) r_use_fb <= !w_pop;
            if (bus_if.frame_start) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_underrun <= 1'b0;
            end else begin
                if (w_push)         r_wptr     <= r_wptr + 1'b1;
                if (w_pop)          r_rptr     <= r_rptr + 1'b1;
                if (w_underrun_evt) r_underrun <= 1'b1;
            end
            if (w_drop && (r_ovf_cnt != 8'hFF)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign w_out_px = r_use_fb ? rgb_t'(FALLBACK_RGB) : w_rd_px;

    assign bus_if.red_out       = w_out_px.r;
    assign bus_if.green_out     = w_out_px.g;
    assign bus_if.blue_out      = w_out_px.b;
    assign bus_if.pix_out_valid = r_pix_out_valid;
    assign bus_if.level         = r_level;
    assign bus_if.afull         = (r_level >= LVL_AFULL);
    assign bus_if.underrun      = r_underrun;
    assign bus_if.overflow_cnt  = r_ovf_cnt;

endmodule
